// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// A single operation is in flight: it is captured, executed for one cycle, and its response is held until consumed.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Requesters may drop valid at any time before their transfer without side effects.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       op_sel_q, op_sel_d;
  logic             op_id_q, op_id_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_id_q    <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= 3'b000;
      op_id_q      <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_id_q    <= last_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      op_id_q      <= op_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_id_d    = last_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    op_id_d      = op_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    // A lone requester wins outright; a tie goes to whoever was not served last.
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else begin
      grant = ~last_id_q;
    end

    req0_ready = (state_q == IDLE) && (grant == 1'b0);
    req1_ready = (state_q == IDLE) && (grant == 1'b1);

    case (state_q)
      IDLE: begin
        if (req0_valid && req0_ready) begin
          op_a_d    = req0_a;
          op_b_d    = req0_b;
          op_sel_d  = req0_sel;
          op_id_d   = 1'b0;
          last_id_d = 1'b0;
          state_d   = EXEC;
        end else if (req1_valid && req1_ready) begin
          op_a_d    = req1_a;
          op_b_d    = req1_b;
          op_sel_d  = req1_sel;
          op_id_d   = 1'b1;
          last_id_d = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_id_d     = op_id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_sel    = op_sel_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, a continuous two-requester stream,
// and an asynchronous reset abort, all against a small model of the shared ALU.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [2:0]       req0_sel;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [2:0]       req1_sel;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             busy;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_id_q[$];

  typedef struct {
    logic [1:0]       mask;
    logic [WIDTH-1:0] a0, b0;
    logic [2:0]       sel0;
    logic [WIDTH-1:0] a1, b1;
    logic [2:0]       sel1;
    int               bp;
    logic             exp_id;
    logic [WIDTH-1:0] exp_res;
    logic             exp_zero;
  } vec_t;

  vec_t vecs[9];

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Shared ALU model: and, or, add, sub, slt; other codes return zero.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    logic [WIDTH-1:0] er;
    logic             ei;
    if (exp_q.size() == 0) begin
      chk("stream_extra_rsp", 1, 0);
    end else begin
      er = exp_q.pop_front();
      ei = exp_id_q.pop_front();
      chk("stream_rsp_result", rsp_result, er);
      chk("stream_rsp_id", rsp_id, ei);
    end
  endtask

  // One transaction with exact cycle timing; bp = cycles of response backpressure.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    req0_valid = v.mask[0]; req0_a = v.a0; req0_b = v.b0; req0_sel = v.sel0;
    req1_valid = v.mask[1]; req1_a = v.a1; req1_b = v.b1; req1_sel = v.sel1;
    rsp_ready  = 1'b0;
    #1;
    chk({tag, "_ready0"}, req0_ready, v.exp_id == 1'b0);
    chk({tag, "_ready1"}, req1_ready, v.exp_id == 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_alu_a"}, alu_a, v.exp_id ? v.a1 : v.a0);
    chk({tag, "_alu_sel"}, alu_sel, v.exp_id ? v.sel1 : v.sel0);
    @(negedge clk);
    #1;
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_id"}, rsp_id, v.exp_id);
    chk({tag, "_rsp_result"}, rsp_result, v.exp_res);
    chk({tag, "_rsp_zero"}, rsp_zero, v.exp_zero);
    for (int k = 0; k < v.bp; k++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk({tag, "_bp_rsp_valid"}, rsp_valid, 1);
      chk({tag, "_bp_rsp_id"}, rsp_id, v.exp_id);
      chk({tag, "_bp_rsp_result"}, rsp_result, v.exp_res);
      chk({tag, "_bp_busy"}, busy, 1);
      chk({tag, "_bp_readies"}, {req0_ready, req1_ready}, 2'b00);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk({tag, "_idle_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_state"}, dbg_state, 2'd0);
  endtask

  // Both requesters held valid; each accepted op is replaced by a fresh one.
  task automatic run_stream();
    int   accepts = 0;
    int   cyc = 0;
    int   last_acc = -1;
    int   pend = 0;
    logic g;
    @(negedge clk);
    rsp_ready = 1'b1;
    req0_a = 1;  req0_b = 100; req0_sel = 3'b010;
    req1_a = 50; req1_b = 0;   req1_sel = 3'b110;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    while (accepts < 4 && cyc < 40) begin
      #1;
      chk("stream_one_ready", req0_ready & req1_ready, 0);
      if (rsp_valid) pop_check();
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        chk("stream_order", g, accepts % 2);
        if (last_acc >= 0) chk("stream_interval", cyc - last_acc, 3);
        exp_q.push_back(g ? req1_a - req1_b : req0_a + req0_b);
        exp_id_q.push_back(g);
        accepts++;
        last_acc = cyc;
        pend = g ? 2 : 1;
      end
      @(negedge clk);
      cyc++;
      if (pend == 1) req0_a = req0_a + 1;
      if (pend == 2) req1_b = req1_b + 1;
      pend = 0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rsp_valid) pop_check();
      @(negedge clk);
    end
    chk("stream_accepts", accepts, 4);
    chk("stream_pending", exp_q.size(), 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{2'b01, 32'd5, 32'd7, 3'b010, 32'd0, 32'd0, 3'b000, 0, 1'b0, 32'd12, 1'b0};
    vecs[1] = '{2'b10, 32'd0, 32'd0, 3'b000, 32'd9, 32'd9, 3'b110, 0, 1'b1, 32'd0, 1'b1};
    vecs[2] = '{2'b10, 32'd0, 32'd0, 3'b000, 32'd3, 32'd4, 3'b111, 0, 1'b1, 32'd1, 1'b0};
    vecs[3] = '{2'b11, 32'hF0, 32'h3C, 3'b000, 32'd1, 32'd1, 3'b010, 0, 1'b0, 32'h30, 1'b0};
    vecs[4] = '{2'b11, 32'd1, 32'd1, 3'b010, 32'hF0, 32'h0F, 3'b001, 5, 1'b1, 32'hFF, 1'b0};
    vecs[5] = '{2'b01, 32'd1, 32'd2, 3'b011, 32'd0, 32'd0, 3'b000, 0, 1'b0, 32'd0, 1'b1};
    vecs[6] = '{2'b11, 32'd2, 32'd2, 3'b010, 32'hFFFF_FFFF, 32'd1, 3'b010, 0, 1'b1, 32'd0, 1'b1};
    vecs[7] = '{2'b11, 32'd7, 32'd3, 3'b110, 32'd8, 32'd8, 3'b000, 2, 1'b0, 32'd4, 1'b0};
    vecs[8] = '{2'b10, 32'd0, 32'd0, 3'b000, 32'd5, 32'd3, 3'b111, 0, 1'b1, 32'd0, 1'b1};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
    rsp_ready = 1'b0;
    #2;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_sel", alu_sel, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_id", rsp_id, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    run_stream();

    // Reset asserted mid-cycle while req1's operation is executing.
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8; req1_sel = 3'b010;
    #1;
    chk("abort_ready1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    chk("abort_exec_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_sel", alu_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("abort_no_rsp", rsp_valid, 0);
      chk("abort_idle_busy", busy, 0);
    end
    rv = '{2'b11, 32'd20, 32'd22, 3'b010, 32'd1, 32'd1, 3'b110, 0, 1'b0, 32'd42, 1'b0};
    run_vec(rv, "post_reset_tie");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
